// File: rtl/cpu_pkg.sv
// Shared widths and helpers for the integer register-file write path.
// Pure declarations; no timing or flow-control behaviour lives here.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int LD_DEPTH   = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  // One-hot register mask; x0 never appears because it is never pending.
  function automatic reg_mask_t reg_onehot(input reg_addr_t a);
    reg_mask_t v;
    v = '0;
    if (a != '0) v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_ld_fifo.sv
// In-order queue of load destination addresses; head visible combinationally.
// Zero-latency head, push ignored when full and pop ignored when empty.
module wb_ld_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = LD_DEPTH,
  parameter int W     = REG_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = PW + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write front end: ALU results and in-order load returns, plus RAW scoreboard.
// One registered cycle to the write port; ALU wins arbitration and load returns wait while it writes.
module regfile_writeback #(
  parameter int XLEN     = cpu_pkg::XLEN,
  parameter int LD_DEPTH = cpu_pkg::LD_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          ld_issue_valid,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] ld_issue_rd,
  output logic                          ld_issue_ready,
  input  logic                          ld_rsp_valid,
  input  logic [XLEN-1:0]               ld_rsp_data,
  output logic                          ld_rsp_ready,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] rs1,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] rs2,
  output logic                          stall,
  output logic [cpu_pkg::NUM_REGS-1:0]  busy,
  output logic [cpu_pkg::REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]               w_data,
  output logic                          reg_write
);

  import cpu_pkg::*;

  logic      alu_win;
  logic      ld_push;
  logic      ld_pop;
  logic      fifo_full;
  logic      fifo_empty;
  reg_addr_t head_rd;
  reg_mask_t busy_q;
  reg_mask_t busy_set;
  reg_mask_t busy_clr;

  assign alu_win        = alu_valid && (alu_rd != '0);
  assign ld_issue_ready = !fifo_full && ((ld_issue_rd == '0) || !busy_q[ld_issue_rd]);
  assign ld_push        = ld_issue_valid && ld_issue_ready;
  assign ld_rsp_ready   = !fifo_empty && !alu_win;
  assign ld_pop         = ld_rsp_valid && ld_rsp_ready;

  wb_ld_fifo #(
    .DEPTH (LD_DEPTH),
    .W     (REG_ADDR_W)
  ) u_ld_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (ld_push),
    .push_dat (ld_issue_rd),
    .pop      (ld_pop),
    .head     (head_rd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd        <= '0;
      w_data    <= '0;
      reg_write <= 1'b0;
    end else if (alu_win) begin
      rd        <= alu_rd;
      w_data    <= alu_data;
      reg_write <= 1'b1;
    end else if (ld_pop) begin
      rd        <= head_rd;
      w_data    <= ld_rsp_data;
      reg_write <= (head_rd != '0);
    end else begin
      reg_write <= 1'b0;
    end
  end

  // Clear on the edge the file is written; a same-edge new issue must survive.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (ld_push)   busy_set = reg_onehot(ld_issue_rd);
    if (reg_write) busy_clr = reg_onehot(rd);
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= (busy_q & ~busy_clr) | busy_set;
  end

  assign busy  = busy_q;
  assign stall = ((rs1 != '0) && busy_q[rs1]) || ((rs2 != '0) && busy_q[rs2]);

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized scoreboard bench for regfile_writeback against a queue/array reference model.
module tb_regfile_writeback;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_issue_valid = 1'b0;
  logic [4:0]  ld_issue_rd = '0;
  logic        ld_issue_ready;
  logic        ld_rsp_valid = 1'b0;
  logic [31:0] ld_rsp_data = '0;
  logic        ld_rsp_ready;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic        stall;
  logic [31:0] busy;
  logic [4:0]  rd;
  logic [31:0] w_data;
  logic        reg_write;

  regfile_writeback #(.XLEN(32), .LD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .ld_rsp_valid(ld_rsp_valid), .ld_rsp_data(ld_rsp_data), .ld_rsp_ready(ld_rsp_ready),
    .rs1(rs1), .rs2(rs2), .stall(stall), .busy(busy),
    .rd(rd), .w_data(w_data), .reg_write(reg_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stamp;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  wr_t         exp_q[$];

  // Reference model: pending-register set, queue of outstanding load targets,
  // the register-file port contents, and the write that lands on the next edge.
  bit          busy_m[32];
  logic [4:0]  ldq[$];
  logic [4:0]  out_rd;
  logic [31:0] out_data;
  bit          landing_vld;
  logic [4:0]  landing_rd;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = busy_m[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    ldq.delete();
    out_rd      = '0;
    out_data    = '0;
    landing_vld = 1'b0;
    landing_rd  = '0;
  endtask

  task automatic idle();
    alu_valid      = 1'b0;
    ld_issue_valid = 1'b0;
    ld_rsp_valid   = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, cross the edge.
  task automatic tick();
    bit         alu_w, ready_e, rsp_ready_e, stall_e, new_vld;
    logic [4:0] head, new_rd;
    @(negedge clk);
    alu_w       = alu_valid && alu_rd != 0;
    ready_e     = (ldq.size() < DEPTH) && (ld_issue_rd == 0 || !busy_m[ld_issue_rd]);
    rsp_ready_e = (ldq.size() > 0) && !alu_w;
    stall_e     = (rs1 != 0 && busy_m[rs1]) || (rs2 != 0 && busy_m[rs2]);
    chk("issue_ready", {31'd0, ld_issue_ready}, {31'd0, ready_e});
    chk("rsp_ready",   {31'd0, ld_rsp_ready},   {31'd0, rsp_ready_e});
    chk("stall",       {31'd0, stall},          {31'd0, stall_e});
    chk("busy",        busy,                    busy_vec());
    chk("rd_hold",     {27'd0, rd},             {27'd0, out_rd});
    chk("wdata_hold",  w_data,                  out_data);
    if (rst) begin
      model_reset();
    end else begin
      new_vld = 1'b0;
      new_rd  = '0;
      if (alu_w) begin
        new_vld  = 1'b1;
        new_rd   = alu_rd;
        out_rd   = alu_rd;
        out_data = alu_data;
        exp_q.push_back('{cyc + 1, alu_rd, alu_data});
      end else if (ld_rsp_valid && rsp_ready_e) begin
        head     = ldq.pop_front();
        out_rd   = head;
        out_data = ld_rsp_data;
        if (head != 0) begin
          new_vld = 1'b1;
          new_rd  = head;
          exp_q.push_back('{cyc + 1, head, ld_rsp_data});
        end
      end
      // A register stops being pending once its write has reached the file.
      if (landing_vld) busy_m[landing_rd] = 1'b0;
      if (ld_issue_valid && ready_e) begin
        ldq.push_back(ld_issue_rd);
        if (ld_issue_rd != 0) busy_m[ld_issue_rd] = 1'b1;
      end
      landing_vld = new_vld;
      landing_rd  = new_rd;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle, a write is either due (and must match) or the port is idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].stamp == cyc) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_en",   {31'd0, reg_write}, 32'd1);
        chk("wr_rd",   {27'd0, rd},        {27'd0, e.rd});
        chk("wr_data", w_data,             e.data);
      end else begin
        chk("wr_idle", {31'd0, reg_write}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst)
      assert (!(alu_valid && alu_rd != 5'd0 && busy[alu_rd]))
        else $error("WAW: alu write to pending register %0d", alu_rd);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [4:0] r);
    idle();
    ld_issue_valid = 1'b1;
    ld_issue_rd    = r;
    tick();
  endtask

  task automatic respond(input logic [31:0] d);
    idle();
    ld_rsp_valid = 1'b1;
    ld_rsp_data  = d;
    tick();
  endtask

  initial begin
    logic [31:0] rsp_vals [4];
    rsp_vals[0] = 32'hAAAA0001; rsp_vals[1] = 32'hBBBB0002;
    rsp_vals[2] = 32'hCCCC0003; rsp_vals[3] = 32'hDDDD0004;

    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_rd",        {27'd0, rd},           32'd0);
    chk("rst_wdata",     w_data,                32'd0);
    chk("rst_reg_write", {31'd0, reg_write},    32'd0);
    chk("rst_busy",      busy,                  32'd0);
    chk("rst_rsp_ready", {31'd0, ld_rsp_ready}, 32'd0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // ALU write to x5
    idle(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF; tick();
    idle(); repeat (2) tick();

    // Single load to x7 with a stalled reader
    rs1 = 5'd7;
    issue(5'd7);
    idle(); repeat (2) tick();
    respond(32'h12345678);
    idle(); repeat (3) tick();
    rs1 = 5'd0;

    // Fill the queue, fifth issue blocked until the first pop
    for (int i = 1; i <= 4; i++) issue(5'(i));
    issue(5'd9);
    for (int i = 0; i < 4; i++) begin
      idle();
      ld_rsp_valid = 1'b1; ld_rsp_data = rsp_vals[i];
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd9;
      if (i > 0) ld_issue_valid = 1'b0;
      if (i == 1) ld_issue_valid = 1'b1;
      tick();
    end
    respond(32'h99990009);
    idle(); tick();

    // ALU and load response collide; load waits with data held
    issue(5'd11);
    idle(); alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0A0A0A0A;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h55AA55AA; tick();
    respond(32'h55AA55AA);
    idle(); tick();

    // x0 load, then ALU to x0 alongside a response
    issue(5'd0);
    respond(32'hFFFFFFFF);
    issue(5'd12);
    idle(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h11111111;
    ld_rsp_valid = 1'b1; ld_rsp_data = 32'h0BADF00D; tick();
    idle(); tick();

    // Reset with loads in flight
    rs1 = 5'd13; rs2 = 5'd14;
    issue(5'd13);
    issue(5'd14);
    idle(); rst = 1'b1; tick();
    rst = 1'b0;
    respond(32'h57A1E000);
    issue(5'd15);
    respond(32'h0000F15E);
    idle(); repeat (2) tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] r;
      idle();
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      ld_issue_valid = ($urandom_range(0, 99) < 40);
      ld_issue_rd    = 5'($urandom_range(0, 15));
      ld_rsp_valid   = ($urandom_range(0, 99) < 55);
      ld_rsp_data    = $urandom;
      r = 5'($urandom_range(0, 31));
      alu_rd   = r;
      alu_data = $urandom;
      alu_valid = ($urandom_range(0, 99) < 35) && !busy_m[r] &&
                  !(ld_issue_valid && ld_issue_rd == r && r != 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
      rst = 1'b0;
    end

    idle(); repeat (6) tick();
    chk("drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
